pipeline_pc_ctrl: RTL and testbench

//  Central next-PC and hazard controller for the 5-stage MIPS pipeline. Decides each cycle which

---
 rtl/pipeline_pc_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_pc_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_pc_ctrl.sv
// Next-PC source and hazard control for the 5-stage pipeline: load-use stalls, jumps,
// taken branches, undefined-opcode exceptions and a synchronised, deferred interrupt.
module pipeline_pc_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] SRC_IRQ     = 3'd4,
    parameter logic [2:0] SRC_EXC     = 3'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       irq,
    input  logic       kernel_mode,
    input  logic       id_jump,
    input  logic       id_jr,
    input  logic       id_undef,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    output logic [2:0] pc_src,
    output logic       stall,
    output logic       if_flush,
    output logic       id_flush,
    output logic       irq_ack,
    output logic       exc_ack,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_PEND    = 2'd1,
        S_TAKE    = 2'd2,
        S_SERVICE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   irq_s;
    logic                   load_use;

    logic [2:0] pc_src_c;
    logic       stall_c, if_flush_c, id_flush_c, irq_ack_c, exc_ack_c;

    assign irq_s    = sync_q[SYNC_STAGES-1];
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= S_RUN;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], irq};
            state_q <= state_d;
        end
    end

    // A taken branch squashes everything younger, so it outranks even the interrupt vector.
    always_comb begin
        pc_src_c   = 3'd0;
        stall_c    = 1'b0;
        if_flush_c = 1'b0;
        id_flush_c = 1'b0;
        irq_ack_c  = 1'b0;
        exc_ack_c  = 1'b0;
        if (ex_branch_taken) begin
            pc_src_c   = 3'd1;
            if_flush_c = 1'b1;
            id_flush_c = 1'b1;
        end else if (state_q == S_TAKE) begin
            pc_src_c   = SRC_IRQ;
            if_flush_c = 1'b1;
            id_flush_c = 1'b1;
            irq_ack_c  = 1'b1;
        end else if (load_use) begin
            stall_c    = 1'b1;
            id_flush_c = 1'b1;
        end else if (id_undef) begin
            pc_src_c   = SRC_EXC;
            if_flush_c = 1'b1;
            exc_ack_c  = 1'b1;
        end else if (id_jr) begin
            pc_src_c   = 3'd3;
            if_flush_c = 1'b1;
        end else if (id_jump) begin
            pc_src_c   = 3'd2;
            if_flush_c = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:     if (irq_s && !kernel_mode) state_d = S_PEND;
            S_PEND: begin
                if (!irq_s)
                    state_d = S_RUN;
                else if (!ex_branch_taken && !load_use && !id_undef)
                    state_d = S_TAKE;
            end
            S_TAKE:    if (!ex_branch_taken) state_d = S_SERVICE;
            S_SERVICE: if (!kernel_mode) state_d = S_RUN;
            default:   state_d = S_RUN;
        endcase
    end

    // Outputs are forced quiet for as long as reset is held, not just after the next edge.
    assign pc_src    = reset ? pc_src_c : 3'd0;
    assign stall     = reset & stall_c;
    assign if_flush  = reset & if_flush_c;
    assign id_flush  = reset & id_flush_c;
    assign irq_ack   = reset & irq_ack_c;
    assign exc_ack   = reset & exc_ack_c;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_pc_ctrl.sv
// Randomised bench for pipeline_pc_ctrl against a rule-level reference model of the
// priority list and interrupt handshake.
module tb_pipeline_pc_ctrl;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset, irq, kernel_mode, id_jump, id_jr, id_undef, id_uses_rt;
    logic       ex_mem_read, ex_branch_taken;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic [2:0] pc_src;
    logic       stall, if_flush, id_flush, irq_ack, exc_ack;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: raw irq history plus three interrupt-progress flags.
    bit irq_hist[$];
    bit m_wait, m_due, m_handle;

    always #5 clk = ~clk;

    pipeline_pc_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .irq(irq), .kernel_mode(kernel_mode),
        .id_jump(id_jump), .id_jr(id_jr), .id_undef(id_undef),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .pc_src(pc_src), .stall(stall), .if_flush(if_flush), .id_flush(id_flush),
        .irq_ack(irq_ack), .exc_ack(exc_ack), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_irq_s();
        if (irq_hist.size() >= SYNC) return irq_hist[SYNC-1];
        return 1'b0;
    endfunction

    function automatic bit m_load_use();
        return ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    // Packed as {pc_src, stall, if_flush, id_flush, irq_ack, exc_ack}.
    function automatic logic [7:0] model_out();
        if (!reset)              return 8'h00;
        if (ex_branch_taken)     return {3'd1, 5'b01100};
        if (m_due)               return {3'd4, 5'b01110};
        if (m_load_use())        return {3'd0, 5'b10100};
        if (id_undef)            return {3'd5, 5'b01001};
        if (id_jr)               return {3'd3, 5'b01000};
        if (id_jump)             return {3'd2, 5'b01000};
        return 8'h00;
    endfunction

    task automatic model_clear();
        irq_hist.delete();
        m_wait = 0; m_due = 0; m_handle = 0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_clear();
            return;
        end
        if (m_handle) begin
            if (!kernel_mode) m_handle = 0;
        end else if (m_due) begin
            if (!ex_branch_taken) begin m_due = 0; m_handle = 1; end
        end else if (m_wait) begin
            if (!m_irq_s()) m_wait = 0;
            else if (!ex_branch_taken && !m_load_use() && !id_undef) begin
                m_wait = 0; m_due = 1;
            end
        end else if (m_irq_s() && !kernel_mode) begin
            m_wait = 1;
        end
        irq_hist.push_front(irq);
        if (irq_hist.size() > SYNC) void'(irq_hist.pop_back());
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input string tag);
        #1;
        check(tag, {pc_src, stall, if_flush, id_flush, irq_ack, exc_ack}, model_out());
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        id_jump = 0; id_jr = 0; id_undef = 0; id_uses_rt = 0;
        ex_mem_read = 0; ex_branch_taken = 0;
        id_rs = 0; id_rt = 0; ex_rt = 0;
    endtask

    initial begin
        int edges;
        int acks;
        reset = 0; irq = 0; kernel_mode = 0;
        quiet_inputs();
        model_clear();
        @(negedge clk);
        id_jump = 1; ex_branch_taken = 1;
        step("reset_quiet");
        quiet_inputs();
        reset = 1;
        step("idle");

        // Load-use stall, then the same with ex_rt = 0.
        ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
        step("load_use");
        check("load_use_stall", stall, 1'b1);
        ex_rt = 5'd0; id_rs = 5'd0;
        step("load_use_r0");
        check("r0_no_stall", stall, 1'b0);

        // Taken branch beats jump and load-use.
        ex_rt = 5'd9; id_rs = 5'd9; id_jump = 1; ex_branch_taken = 1;
        step("branch_wins");
        check("branch_src", pc_src, 3'd1);
        quiet_inputs();

        // Undefined opcode in kernel mode still traps.
        kernel_mode = 1; id_undef = 1;
        step("undef_kernel");
        check("exc_ack", exc_ack, 1'b1);
        quiet_inputs();
        kernel_mode = 0;
        step("idle2");

        // Interrupt latency from RUN, then masked re-entry while in the handler.
        irq = 1;
        edges = 0;
        while (!irq_ack && edges < 20) begin
            step("irq_lat_cycle");
            edges++;
        end
        check("irq_latency", edges, SYNC + 2);
        check("irq_vector", pc_src, 3'd4);
        kernel_mode = 1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step("service_hold");
            acks += int'(irq_ack);
        end
        check("no_reack_in_service", acks, 0);
        kernel_mode = 0;
        step("service_exit");
        step("repend");
        // Now pending again: a taken branch must delay the vector by one clean cycle.
        ex_branch_taken = 1;
        step("pend_branch");
        check("pend_branch_noack", irq_ack, 1'b0);
        ex_branch_taken = 0;
        step("pend_clean");
        check("ack_after_branch", irq_ack, 1'b1);
        kernel_mode = 1;
        step("into_service");

        // Reset in SERVICE: quiet immediately, no ack afterwards with irq low.
        reset = 0; irq = 0;
        model_clear();
        #1;
        check("reset_async_out", {pc_src, stall, if_flush, id_flush, irq_ack, exc_ack}, 8'h00);
        step("reset_hold");
        reset = 1; kernel_mode = 0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            step("post_reset");
            acks += int'(irq_ack);
        end
        check("no_ack_after_reset", acks, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) irq = ~irq;
            if ($urandom_range(0, 7) == 0)  kernel_mode = ~kernel_mode;
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            ex_mem_read     = ($urandom_range(0, 3) == 0);
            ex_rt           = 5'($urandom_range(0, 3));
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_undef        = ($urandom_range(0, 11) == 0);
            id_jump         = ($urandom_range(0, 7) == 0);
            id_jr           = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 0;
                model_clear();
                step("rand_reset");
                reset = 1;
            end else begin
                step("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
